// File: rtl/escalonador_rr.sv
// Purpose : round-robin time-slice scheduler for user processes 1..3; process 0 (kernel) runs otherwise.
// Latency : cria_proc -> prontos 1 cycle; IDLE/ctx_ack -> id_proc nonzero 2 edges; slice = QUANTUM RUN + 1 TROCA cycle.
// Backpress: no valid/ready; after every switch or halt the scheduler stalls in ESPERA until ctx_ack.
//
// Ports:
//   clk, reset (async, active-high)
//   enable       : allow dispatch of user processes
//   atualPC      : current PC, saved into the preempted process's slot at quantum expiry
//   halt         : running process finished; drops it from the ready mask
//   cria_proc/cria_id/cria_pc : register (or re-register) a process and its start PC; id 0 ignored
//   ctx_ack      : kernel switch routine finished
//   id_proc      : running process id (0 = kernel)
//   troca_ctx    : one-cycle context-switch pulse, id_proc still holds the preempted id
//   pc_restaura  : resume PC of the process in id_proc
//   prontos      : ready mask, bit i-1 = process i
//   ocioso       : no process ready
//
// Build option: SCHED_RENOVA_EN -- a lone ready process renews its slice in place
// instead of going through TROCA/ESPERA.

module escalonador_rr #(
    parameter int QUANTUM = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] atualPC,
    input  logic        halt,
    input  logic        cria_proc,
    input  logic [1:0]  cria_id,
    input  logic [31:0] cria_pc,
    input  logic        ctx_ack,
    output logic [1:0]  id_proc,
    output logic        troca_ctx,
    output logic [31:0] pc_restaura,
    output logic [2:0]  prontos,
    output logic        ocioso
);

    localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DISPATCH,
        RUN,
        TROCA,
        ESPERA
    } estado_t;

    estado_t       estado;
    estado_t       proxEstado;
    logic [CW-1:0] contador;
    logic [1:0]    lastId;
    logic [1:0]    proxId;
    logic [31:0]   pcProx;
    logic [31:0]   savedPc [3];
    logic [2:0]    maskAtual;
    logic [2:0]    criaMask;
    logic [2:0]    prontosProx;
    logic          fimQuantum;
    logic          renova;
    logic          salvaPc;

    assign ocioso     = (prontos == 3'b000);
    assign fimQuantum = (contador == CW'(QUANTUM - 1));

    // One-hot of the running process; id 0 shifts the bit out and yields an empty mask.
    assign maskAtual = (id_proc == 2'd0) ? 3'b000 : (3'b001 << (id_proc - 2'd1));
    assign criaMask  = (cria_proc && cria_id != 2'd0) ? (3'b001 << (cria_id - 2'd1)) : 3'b000;

    // Slice renewal only when the running process is the sole ready one.
    always_comb begin
        renova = 1'b0;
`ifdef SCHED_RENOVA_EN
        renova = (prontos == maskAtual);
`endif
    end

    // Cyclic search starting just after lastId; uses the mask from before the edge,
    // so a process registered in the same cycle is not yet a candidate.
    always_comb begin
        proxId = 2'd0;
        case (lastId)
            2'd1:    proxId = prontos[1] ? 2'd2 : prontos[2] ? 2'd3 : prontos[0] ? 2'd1 : 2'd0;
            2'd2:    proxId = prontos[2] ? 2'd3 : prontos[0] ? 2'd1 : prontos[1] ? 2'd2 : 2'd0;
            default: proxId = prontos[0] ? 2'd1 : prontos[1] ? 2'd2 : prontos[2] ? 2'd3 : 2'd0;
        endcase
    end

    always_comb begin
        pcProx = 32'd0;
        case (proxId)
            2'd1:    pcProx = savedPc[0];
            2'd2:    pcProx = savedPc[1];
            2'd3:    pcProx = savedPc[2];
            default: pcProx = 32'd0;
        endcase
    end

    // Halt clears first, then a registration sets, so a re-registration in the
    // halt cycle keeps the process ready.
    always_comb begin
        prontosProx = prontos;
        if (estado == RUN && halt) begin
            prontosProx = prontosProx & ~maskAtual;
        end
        prontosProx = prontosProx | criaMask;
    end

    assign salvaPc = (estado == RUN) && !halt && fimQuantum && !renova;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= IDLE;
        end else begin
            estado <= proxEstado;
        end
    end

    // FSM next state and outputs
    always_comb begin
        proxEstado = estado;
        troca_ctx  = 1'b0;
        case (estado)
            IDLE: begin
                if (enable && prontos != 3'b000) proxEstado = DISPATCH;
            end
            DISPATCH: begin
                proxEstado = (prontos != 3'b000) ? RUN : IDLE;
            end
            RUN: begin
                if (halt) begin
                    proxEstado = ESPERA;
                end else if (fimQuantum && !renova) begin
                    proxEstado = TROCA;
                end
            end
            TROCA: begin
                troca_ctx  = 1'b1;
                proxEstado = ESPERA;
            end
            ESPERA: begin
                if (ctx_ack) begin
                    proxEstado = (enable && prontos != 3'b000) ? DISPATCH : IDLE;
                end
            end
            default: proxEstado = IDLE;
        endcase
    end

    // Running id, resume PC, slice counter, ready mask
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_proc     <= 2'd0;
            pc_restaura <= 32'd0;
            lastId      <= 2'd3;
            contador    <= '0;
            prontos     <= 3'b000;
        end else begin
            prontos <= prontosProx;
            case (estado)
                DISPATCH: begin
                    if (prontos != 3'b000) begin
                        id_proc     <= proxId;
                        pc_restaura <= pcProx;
                        lastId      <= proxId;
                        contador    <= '0;
                    end else begin
                        id_proc <= 2'd0;
                    end
                end
                RUN: begin
                    if (halt) begin
                        id_proc <= 2'd0;
                    end else if (fimQuantum && renova) begin
                        contador <= '0;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end
                // Leaving TROCA the kernel takes over; IDLE/ESPERA keep the kernel.
                default: id_proc <= 2'd0;
            endcase
        end
    end

    // Per-process PC table; a registration overrides a same-cycle expiry save.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) savedPc[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (criaMask[i]) begin
                    savedPc[i] <= cria_pc;
                end else if (salvaPc && maskAtual[i]) begin
                    savedPc[i] <= atualPC;
                end
            end
        end
    end

endmodule

// File: tb/tb_escalonador_rr.sv
module tb_escalonador_rr;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] atualPC;
    logic        halt;
    logic        cria_proc;
    logic [1:0]  cria_id;
    logic [31:0] cria_pc;
    logic        ctx_ack;
    logic [1:0]  id_proc;
    logic        troca_ctx;
    logic [31:0] pc_restaura;
    logic [2:0]  prontos;
    logic        ocioso;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] pc;
    } disp_t;

    disp_t       expQ [$];
    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] lastPC;

    escalonador_rr #(.QUANTUM(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .atualPC(atualPC), .halt(halt),
        .cria_proc(cria_proc), .cria_id(cria_id), .cria_pc(cria_pc), .ctx_ack(ctx_ack),
        .id_proc(id_proc), .troca_ctx(troca_ctx), .pc_restaura(pc_restaura),
        .prontos(prontos), .ocioso(ocioso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock; lastPC is the atualPC value the DUT saw on that edge.
    task automatic step();
        @(posedge clk);
        #1;
        lastPC  = atualPC;
        atualPC = atualPC + 32'd4;
    endtask

    task automatic criar(input logic [1:0] id, input logic [31:0] pc);
        cria_proc = 1'b1;
        cria_id   = id;
        cria_pc   = pc;
        step();
        cria_proc = 1'b0;
    endtask

    task automatic chkReset(input string tag);
        chk({tag, "_id"}, 32'(id_proc), 32'd0);
        chk({tag, "_troca"}, 32'(troca_ctx), 32'd0);
        chk({tag, "_pc"}, pc_restaura, 32'd0);
        chk({tag, "_prontos"}, 32'(prontos), 32'd0);
        chk({tag, "_ocioso"}, 32'(ocioso), 32'd1);
    endtask

    // Wait for a dispatch, check its latency and pop the scoreboard.
    task automatic dispatchCheck(input int expLat);
        int    n = 0;
        disp_t e;
        while (id_proc == 2'd0 && n < 20) begin
            step();
            n++;
        end
        chk("disp_lat", n, expLat);
        if (expQ.size() == 0) begin
            chk("sb_underflow", 32'(expQ.size()), 32'd1);
        end else begin
            e = expQ.pop_front();
            chk("disp_id", 32'(id_proc), 32'(e.id));
            chk("disp_pc", pc_restaura, e.pc);
        end
        ctx_ack = 1'b0;
    endtask

    // From the first RUN sample: expect 8 RUN cycles, a one-cycle TROCA, then ESPERA.
    task automatic runSlice(input logic [1:0] expId, output logic [31:0] saved);
        int n = 0;
        while (id_proc == expId && !troca_ctx && n < 40) begin
            n++;
            step();
        end
        chk("run_len", n, 8);
        chk("troca_pulse", 32'(troca_ctx), 32'd1);
        chk("troca_id", 32'(id_proc), 32'(expId));
        saved = lastPC;
        step();
        chk("troca_end", 32'(troca_ctx), 32'd0);
        chk("espera_id", 32'(id_proc), 32'd0);
    endtask

    // Acknowledge 3 cycles after entering ESPERA, expect next dispatch 2 edges later.
    task automatic ackSwitch();
        step();
        step();
        ctx_ack = 1'b1;
        dispatchCheck(2);
    endtask

    initial begin
        logic [31:0] s1, s2, s3, s1b, sx;
        logic        sawTroca;
        reset = 1'b1; enable = 1'b0; atualPC = 32'h1000; halt = 1'b0;
        cria_proc = 1'b0; cria_id = 2'd0; cria_pc = 32'd0; ctx_ack = 1'b0;
        lastPC = 32'h0;
        step();
        step();
        chkReset("rst");
        reset = 1'b0;

        // Single process 1
        enable = 1'b1;
        expQ.push_back('{2'd1, 32'h40});
        criar(2'd1, 32'h40);
        chk("t1_prontos", 32'(prontos), 32'b001);
        chk("t1_ocioso", 32'(ocioso), 32'd0);
        dispatchCheck(2);
`ifdef SCHED_RENOVA_EN
        sawTroca = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (troca_ctx || id_proc != 2'd1) sawTroca = 1'b1;
        end
        chk("renova_hold", 32'(sawTroca), 32'd0);
`else
        runSlice(2'd1, sx);
        expQ.push_back('{2'd1, sx});
        ackSwitch();
`endif

        // Three processes in rotation
        reset = 1'b1;
        step();
        reset = 1'b0;
        enable = 1'b0;
        criar(2'd0, 32'h999);
        chk("id0_ignored", 32'(prontos), 32'b000);
        criar(2'd1, 32'h40);
        criar(2'd2, 32'h80);
        criar(2'd3, 32'hC0);
        chk("t2_prontos", 32'(prontos), 32'b111);
        expQ.push_back('{2'd1, 32'h40});
        expQ.push_back('{2'd2, 32'h80});
        expQ.push_back('{2'd3, 32'hC0});
        enable = 1'b1;
        dispatchCheck(2);
        runSlice(2'd1, s1);
        expQ.push_back('{2'd1, s1});
        ackSwitch();
        runSlice(2'd2, s2);
        expQ.push_back('{2'd2, s2});
        ackSwitch();
        runSlice(2'd3, s3);
        expQ.push_back('{2'd3, s3});
        ackSwitch();
        runSlice(2'd1, s1b);
        expQ.push_back('{2'd1, s1b});
        ackSwitch();

        // Process 2 halts on its third RUN cycle
        step();
        step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt_id", 32'(id_proc), 32'd0);
        chk("halt_troca", 32'(troca_ctx), 32'd0);
        chk("halt_prontos", 32'(prontos), 32'b101);
        chk("halt_savedpc", dut.savedPc[1], s2);
        sawTroca = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (troca_ctx) sawTroca = 1'b1;
        end
        chk("halt_no_troca", 32'(sawTroca), 32'd0);
        ctx_ack = 1'b1;
        dispatchCheck(2);

        // Process 3 halts exactly at counter == QUANTUM-1
        for (int i = 0; i < 7; i++) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("halt7_id", 32'(id_proc), 32'd0);
        chk("halt7_troca", 32'(troca_ctx), 32'd0);
        chk("halt7_prontos", 32'(prontos), 32'b001);
        chk("halt7_savedpc", dut.savedPc[2], s3);
        ctx_ack = 1'b1;
        dispatchCheck(2);

        // Asynchronous reset while process 3 runs
        reset = 1'b1;
        step();
        reset = 1'b0;
        expQ.push_back('{2'd3, 32'h300});
        criar(2'd3, 32'h300);
        dispatchCheck(2);
        step();
        step();
        chk("pre_rst_id", 32'(id_proc), 32'd3);
        reset = 1'b1;
        #1;
        chkReset("async_rst");
        reset = 1'b0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
